// File: rtl/k12a_pkg.sv
// Shared K12A definitions: skip-register control, sequencer state and the
// opcodes the sequencer itself decodes.
package k12a_pkg;

    typedef enum logic [1:0] {
        SKIP_SEL_HOLD        = 2'd0,
        SKIP_SEL_0           = 2'd1,
        SKIP_SEL_CONDITION   = 2'd2,
        SKIP_SEL_CONDITION_N = 2'd3
    } skip_sel_t;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } seq_state_t;

    localparam logic [3:0] OPCODE_SKIP = 4'hE;
    localparam logic [3:0] OPCODE_HALT = 4'hF;

    // Skip-register control for an instruction that actually executes.
    function automatic skip_sel_t exec_skip_sel(input logic [15:0] instr);
        if (instr[15:12] == OPCODE_SKIP) begin
            return instr[11] ? SKIP_SEL_CONDITION_N : SKIP_SEL_CONDITION;
        end
        return SKIP_SEL_HOLD;
    endfunction

endpackage

// File: rtl/k12a_skip_reg.sv
// One-bit skip flag: loaded from the ALU condition by skip instructions and
// cleared once the following instruction has been squashed.
module k12a_skip_reg
    import k12a_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  skip_sel_t skip_sel,
    input  logic      alu_condition,
    output logic      skip
);

    always_ff @(posedge clock) begin
        if (reset) begin
            skip <= 1'b0;
        end else begin
            case (skip_sel)
                SKIP_SEL_HOLD:        skip <= skip;
                SKIP_SEL_0:           skip <= 1'b0;
                SKIP_SEL_CONDITION:   skip <= alu_condition;
                SKIP_SEL_CONDITION_N: skip <= ~alu_condition;
            endcase
        end
    end

endmodule

// File: rtl/k12a_sequencer.sv
// K12A instruction sequencer: fetches a 16-bit instruction as two bytes,
// executes it for one cycle (or squashes it), and counts retired instructions.
module k12a_sequencer
    import k12a_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic        skip,
    output logic        mem_read,
    output logic        pc_inc,
    output logic [15:0] inst,
    output logic        exec_strobe,
    output skip_sel_t   skip_sel,
    output logic        halted,
    output logic [15:0] retired
);

    seq_state_t  state_q, state_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] retired_q, retired_d;

    assign inst    = inst_q;
    assign retired = retired_q;

    // Strobes are decoded from the current state and inputs so that a byte
    // accepted this cycle advances the PC in the same cycle.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        retired_d   = retired_q;
        mem_read    = 1'b0;
        pc_inc      = 1'b0;
        exec_strobe = 1'b0;
        skip_sel    = SKIP_SEL_HOLD;
        halted      = 1'b0;

        case (state_q)
            FETCH_HI: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    inst_d[15:8] = mem_rdata;
                    pc_inc       = 1'b1;
                    state_d      = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    inst_d[7:0] = mem_rdata;
                    pc_inc      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH_HI;
                if (skip) begin
                    // Squashed: a squashed HALT must not stop the machine.
                    skip_sel = SKIP_SEL_0;
                end else begin
                    exec_strobe = 1'b1;
                    retired_d   = retired_q + 16'd1;
                    skip_sel    = exec_skip_sel(inst_q);
                    if (inst_q[15:12] == OPCODE_HALT) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH_HI;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_HI;
            inst_q    <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/k12a_sequencer.md
K12A_SEQUENCER -- requirements
Module: k12a_sequencer

Interface
REQ-001 Ports SHALL be, in order:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_ready  in  1  memory read data valid this cycle
- mem_rdata  in  8  instruction byte from memory
- skip  in  1  current skip flag from k12a_skip_reg
- mem_read  out  1  request instruction byte read
- pc_inc  out  1  advance PC by one byte
- inst  out  16  latched instruction (hi byte = [15:8])
- exec_strobe  out  1  execute inst this cycle
- skip_sel  out  skip_sel_t  skip-register control to k12a_skip_reg
- halted  out  1  sequencer in HALT state
- retired  out  16  count of executed (non-squashed) instructions
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

Function
REQ-003 The FSM SHALL have exactly four states: FETCH_HI, FETCH_LO, EXEC, HALT.
REQ-004 FETCH_HI: mem_read=1; on mem_ready=1, inst[15:8] <= mem_rdata, pc_inc=1, next state FETCH_LO; otherwise remain, pc_inc=0.
REQ-005 FETCH_LO: mem_read=1; on mem_ready=1, inst[7:0] <= mem_rdata, pc_inc=1, next state EXEC; otherwise remain.
REQ-006 EXEC is exactly one cycle; mem_read=0 and pc_inc=0.
REQ-007 EXEC with skip=1: the instruction is squashed; exec_strobe=0, skip_sel=SKIP_SEL_0, retired unchanged, next state FETCH_HI (even if the squashed opcode is HALT).
REQ-008 EXEC with skip=0: exec_strobe=1 and retired <= retired+1, wrapping 16'hFFFF -> 16'h0000.
REQ-009 EXEC with skip=0 and inst[15:12]==OPCODE_SKIP: skip_sel = SKIP_SEL_CONDITION_N if inst[11]=1, else SKIP_SEL_CONDITION; next state FETCH_HI.
REQ-010 EXEC with skip=0 and inst[15:12]==OPCODE_HALT: skip_sel=SKIP_SEL_HOLD; next state HALT.
REQ-011 EXEC with skip=0, any other opcode: skip_sel=SKIP_SEL_HOLD; next state FETCH_HI.
REQ-012 In FETCH_HI, FETCH_LO and HALT, skip_sel SHALL be SKIP_SEL_HOLD and exec_strobe 0.
REQ-013 HALT: all strobes 0, halted=1; exit only via reset.
REQ-014 mem_read, pc_inc, exec_strobe, skip_sel, halted SHALL be combinational functions of state and current inputs; inst and retired are registered.
REQ-015 mem_rdata SHALL be ignored whenever mem_ready=0 or state is EXEC/HALT.
REQ-016 Minimum instruction period SHALL be 3 cycles (zero-wait memory); skip written at end of EXEC is therefore stable before the next EXEC.

Reset
REQ-017 While reset=1 at a rising edge: state <= FETCH_HI, inst <= 16'h0000, retired <= 16'h0000.
REQ-018 Reset SHALL take priority in any state, including mid-fetch with mem_ready=1 (byte discarded) and HALT.
REQ-019 Outputs the cycle after reset: mem_read=1, pc_inc=0 (until mem_ready), exec_strobe=0, skip_sel=SKIP_SEL_HOLD, halted=0.

Structure
REQ-020 skip_sel_t (existing), the state enum seq_state_t, and constants OPCODE_SKIP=4'hE and OPCODE_HALT=4'hF SHALL live in the shared k12a package include.
REQ-021 No sub-module; the block is one FSM plus inst and retired registers.
REQ-022 k12a_sequencer.skip_sel SHALL connect directly to k12a_skip_reg.skip_sel, and k12a_skip_reg.skip to k12a_sequencer.skip.

Verification
REQ-023 Bench SHALL instantiate k12a_sequencer with k12a_skip_reg and a byte memory model with programmable wait states, covering:
- Reset, zero-wait memory, bytes 12,34 -> inst=16'h1234, exec_strobe=1 on cycle 3, retired=1.
- Skip instr 16'hE000, alu_condition=1, then 16'h1111 -> skip=1 at next EXEC, 16'h1111 squashed, skip_sel=SKIP_SEL_0, retired=1, skip=0 after.
- Skip instr 16'hE800 (inverted), alu_condition=1 -> skip=0, following instruction executes, retired=2.
- 2 wait states per byte -> mem_read held, pc_inc pulses exactly twice per instruction, 7-cycle period.
- 16'hF000 unskipped -> halted=1, no further mem_read; squashed 16'hF000 -> no halt; reset in HALT -> FETCH_HI, retired=0.
- retired preset via 65535 executions -> wraps to 16'h0000; reset asserted in FETCH_LO with mem_ready=1 -> inst=0, state FETCH_HI.
